multichannel_differentiator: RTL
================================

Name: multichannel_differentiator

Overview:
Parametrised successor to the single-tap phase differentiator in the FM demodulator chain. Computes y[n] = x[n] - x[n-DELAY] independently per channel on a time-multiplexed, valid-qualified sample stream. Wrap-around arithmetic converts phase to frequency; optional saturation supports non-phase use. Sits between the phase extractor (CORDIC) and the de-emphasis/decimation stages; one instance serves all interleaved channels.

Parameters:
WIDTH, 16, sample width in bits, two's complement, input and output.
DELAY, 1, differential lag in samples per channel, legal range 1..16.
CHANNELS, 1, number of interleaved channels, legal range 1..8.
SATURATE, 0, 0 = modular wrap (phase mode), 1 = clamp to signed range.
CW (localparam), max(1, clog2(CHANNELS)), channel index width.

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of history and channel sequencing
in_valid  in  1  in_data holds a sample this cycle; block always accepts, no backpressure
in_data  in  WIDTH  signed input sample
out_valid  out  1  out_data/out_chan valid this cycle
out_data  out  WIDTH  signed difference
out_chan  out  CW  channel index of out_data
primed  out  1  every channel holds DELAY samples of history

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_data=0, out_chan=0, primed=0, channel counter=0, all history words=0, all per-channel prime counters=0.
- Channel sequencing: internal counter chan. Each in_valid sample belongs to channel chan. Afterwards chan increments, wrapping CHANNELS-1 -> 0. Idle cycles (in_valid=0) do not advance chan.
- History: per channel, DELAY-entry shift register. On an accepted sample for channel c:
  - diff uses hist[c][DELAY-1] (the sample DELAY accepts ago on that channel);
  - then shift in in_data.
  - Other channels' history is untouched.
- Arithmetic: compute WIDTH+1-bit signed d = in_data - hist[c][DELAY-1].
  - SATURATE=0: out_data = d[WIDTH-1:0] (two's-complement wrap; correct phase unwrap for full-scale phase encoding).
  - SATURATE=1: d > 2^(WIDTH-1)-1 -> max; d < -2^(WIDTH-1) -> min; else d.
- Latency: one cycle. Sample accepted at edge k -> out_valid/out_data/out_chan at edge k+1. out_valid is a single-cycle pulse per qualifying sample. out_data/out_chan hold their last value while out_valid=0.
- Priming: per-channel counter saturating at DELAY, incremented per accepted sample of that channel. The sample is output (out_valid=1) only if that channel's counter already equals DELAY before the sample. The first DELAY samples of each channel update history but produce no output.
- primed = 1 once all CHANNELS counters equal DELAY; registered, updates with the same edge as the counter.
- clear=1 at an edge: same state as reset except it is synchronous. out_valid=0 the following cycle. A simultaneous in_valid sample is discarded: no history, counter or chan update.
- Reset asserted mid-stream: immediate return to reset state, including an in-flight out_valid. Post-reset stream restarts at channel 0, unprimed.
- in_valid on consecutive cycles at full rate: supported with no bubbles. Back-to-back samples to the same channel (CHANNELS=1) use the just-written history correctly.
- Illegal parameters (DELAY or CHANNELS out of range) fail elaboration.

Test Plan:
- WIDTH=16, DELAY=1, CHANNELS=1, SATURATE=0; drive 100, 250, 200 on consecutive cycles -> no output for 100; then out_data=150, then -50, each one cycle after input; primed=1 after first sample.
- Phase wrap, same config; drive 0x7FF0 then 0x8010 -> out_data=0x0020 (+32). Repeat with SATURATE=1 -> out_data=0x8000.
- CHANNELS=2, DELAY=2; drive 10, 1000, 20, 2000, 40, 4000 with random in_valid gaps -> exactly two outputs: (chan 0, 30) then (chan 1, 3000); primed rises after the 4th sample.
- CHANNELS=3, DELAY=1, continuous stream; assert clear together with in_valid mid-stream -> that sample dropped, out_valid=0 next cycle, next sample mapped to channel 0 with no output, primed=0 until 3 further samples.
- Assert reset_n low asynchronously between edges while out_valid=1 -> out_valid, out_data, primed drop to 0 immediately; after release, behaviour identical to a fresh start.
- Randomised CHANNELS/DELAY/SATURATE against a reference model for 10k samples -> exact match of out_data, out_chan and out_valid timing.

Source files
------------

// File: rtl/multichannel_differentiator_if.sv
// Sample stream bundle for the multichannel differentiator.
// The master side drives samples; the slave side returns differences.
interface multichannel_differentiator_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 1
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic [CW-1:0]           out_chan;
  logic                    primed;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_chan, primed
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_chan, primed
  );
endinterface

// File: rtl/multichannel_differentiator.sv
// Per-channel y[n] = x[n] - x[n-DELAY] on an interleaved sample stream.
// Wraps by default (phase to frequency); optional clamp to signed range.
module multichannel_differentiator #(
  parameter int WIDTH    = 16,
  parameter int DELAY    = 1,
  parameter int CHANNELS = 1,
  parameter int SATURATE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  multichannel_differentiator_if.slave s
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NS = 1 << CW;
  localparam int PW = $clog2(DELAY + 1);

  typedef logic signed [WIDTH-1:0] smp_t;
  typedef logic [PW-1:0] cnt_t;

  localparam cnt_t          FULL = cnt_t'(DELAY);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
  localparam smp_t SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam smp_t SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("DELAY must be in 1..16");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_chan
      $error("CHANNELS must be in 1..8");
    end
  endgenerate

  // Arrays padded to a power of two so chan indexes them cleanly.
  smp_t          hist [NS][DELAY];
  cnt_t          cnt  [NS];
  logic [CW-1:0] chan;

  smp_t                  old;
  logic signed [WIDTH:0] d;
  smp_t                  res;
  logic                  take;
  logic                  fire;
  logic                  all_nx;

  always_comb begin
    take = s.in_valid && !clear;
    fire = take && (cnt[chan] == FULL);
    old  = hist[chan][DELAY-1];
    d    = {s.in_data[WIDTH-1], s.in_data} - {old[WIDTH-1], old};
    res  = d[WIDTH-1:0];
    // Top two bits disagree only when the true difference overflows.
    if (SATURATE != 0 && (d[WIDTH] != d[WIDTH-1])) begin
      res = d[WIDTH] ? SMIN : SMAX;
    end
    all_nx = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!(cnt[i] == FULL ||
            (take && chan == CW'(i) &&
             cnt[i] == FULL - 1'b1))) begin
        all_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan       <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_chan  <= '0;
      s.primed    <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        cnt[i] <= '0;
        for (int j = 0; j < DELAY; j++) hist[i][j] <= '0;
      end
    end else if (clear) begin
      chan       <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_chan  <= '0;
      s.primed    <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        cnt[i] <= '0;
        for (int j = 0; j < DELAY; j++) hist[i][j] <= '0;
      end
    end else begin
      s.out_valid <= fire;
      s.primed    <= all_nx;
      if (fire) begin
        s.out_data <= res;
        s.out_chan <= chan;
      end
      if (take) begin
        hist[chan][0] <= s.in_data;
        for (int j = 1; j < DELAY; j++) begin
          hist[chan][j] <= hist[chan][j-1];
        end
        if (cnt[chan] != FULL) cnt[chan] <= cnt[chan] + 1'b1;
        chan <= (chan == LAST) ? '0 : chan + 1'b1;
      end
    end
  end
endmodule
